// File: rtl/bus_change_fifo.sv
// Change-detect capture: pushes every new bus value into a small FIFO
// and presents the captured values on a valid/ready interface.
module bus_change_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         bus,
    input  logic                     en,
    input  logic                     clear,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic change;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign change = en && (bus != prev_q);
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
                 && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop    = !empty && out_ready;
    // A pop in the same cycle frees the slot the push will land in.
    assign push   = change && (!full || pop);
    assign drop   = change && full && !pop;

    always_comb begin
        prev_d     = bus;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = bus;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end

        if (clear) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
        // A drop in a clearing cycle counts as the first drop after it.
        if (drop) begin
            overflow_d = 1'b1;
            if (clear) begin
                drop_d = CNT_W'(1);
            end else if (drop_q != {CNT_W{1'b1}}) begin
                drop_d = drop_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= '0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            prev_q     <= prev_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign out_data   = mem_q[rd_ptr_q[AW-1:0]];
    assign out_valid  = !empty;
    assign level      = wr_ptr_q - rd_ptr_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_bus_change_fifo.sv
// Scoreboard bench for bus_change_fifo: directed bus changes, queued
// expected captures, and a negedge monitor that checks every pop.
module tb_bus_change_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] bus;
    logic       en;
    logic       clear;
    logic       out_ready;

    logic [7:0] out_data,   out_data2;
    logic       out_valid,  out_valid2;
    logic [2:0] level,      level2;
    logic       overflow,   overflow2;
    logic [7:0] drop_count;
    logic [1:0] drop_count2;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    bus_change_fifo #(.WIDTH(8), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .en(en), .clear(clear),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level), .overflow(overflow), .drop_count(drop_count)
    );

    bus_change_fifo #(.WIDTH(8), .DEPTH(4), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .bus(bus), .en(en), .clear(clear),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
        .level(level2), .overflow(overflow2), .drop_count(drop_count2)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] v, input bit pushed);
        bus = v;
        if (pushed) exp_q.push_back(v);
        step();
    endtask

    // Monitor: a handshake seen mid-cycle completes at the next posedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got %0h, expected none",
                         out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL pop_data: got %0h, expected %0h",
                             out_data, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; bus = 8'h00; en = 1'b1;
        clear = 1'b0; out_ready = 1'b0;
        repeat (3) step();
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_drops", drop_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", out_data, 8'h00);
        rst = 1'b0;
        repeat (3) step();
        chk("idle_valid", out_valid, 0);
        chk("idle_level", level, 0);

        // Two consecutive changes, consumer stalled
        drive(8'h03, 1);
        drive(8'h07, 1);
        chk("t2_level", level, 2);
        chk("t2_head", out_data, 8'h03);
        chk("t2_valid", out_valid, 1);
        out_ready = 1'b1;
        repeat (3) step();
        chk("t2_empty", out_valid, 0);
        chk("t2_level0", level, 0);
        out_ready = 1'b0;

        // Six changes into a 4-deep FIFO: last two dropped
        drive(8'h11, 1);
        drive(8'h22, 1);
        drive(8'h33, 1);
        drive(8'h44, 1);
        drive(8'h55, 0);
        drive(8'h66, 0);
        chk("t3_level", level, 4);
        chk("t3_ovf", overflow, 1);
        chk("t3_drops", drop_count, 2);
        chk("t3_drops_c2", drop_count2, 2);
        out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        chk("t3_drained", level, 0);

        // Full FIFO, push and pop in the same cycle
        drive(8'h81, 1);
        drive(8'h82, 1);
        drive(8'h83, 1);
        drive(8'h84, 1);
        chk("t4_full", level, 4);
        out_ready = 1'b1;
        drive(8'h85, 1);
        out_ready = 1'b0;
        chk("t4_level", level, 4);
        chk("t4_nodrop", drop_count, 2);
        chk("t4_head", out_data, 8'h82);
        out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        chk("t4_drained", level, 0);

        // Saturation with CNT_W=2, then clear, then clear with drop
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t5_clr_ovf", overflow, 0);
        chk("t5_clr_drops", drop_count, 0);
        drive(8'h01, 1);
        drive(8'h02, 1);
        drive(8'h03, 1);
        drive(8'h04, 1);
        drive(8'h05, 0);
        drive(8'h06, 0);
        drive(8'h07, 0);
        drive(8'h08, 0);
        drive(8'h09, 0);
        chk("t5_sat_c2", drop_count2, 3);
        chk("t5_nosat", drop_count, 5);
        chk("t5_ovf", overflow2, 1);
        clear = 1'b1;
        step();
        chk("t5_clr2_c2", drop_count2, 0);
        chk("t5_clr2_ovf", overflow2, 0);
        bus = 8'h0A;
        step();
        clear = 1'b0;
        chk("t5_cd_ovf", overflow, 1);
        chk("t5_cd_drops", drop_count, 1);
        chk("t5_cd_drops_c2", drop_count2, 1);
        chk("t5_cd_level", level, 4);

        // Reset in the middle of a drain
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t6_level3", level, 3);
        out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_level", level, 0);
        chk("t6_async_data", out_data, 8'h00);
        exp_q.delete();
        out_ready = 1'b0;
        bus = 8'hA5;
        step();
        rst = 1'b0;
        exp_q.push_back(8'hA5);
        step();
        step();
        chk("t6_level", level, 1);
        chk("t6_head", out_data, 8'hA5);
        chk("t6_ovf", overflow, 0);
        out_ready = 1'b1;
        repeat (2) step();
        out_ready = 1'b0;
        chk("t6_drained", level, 0);

        // Change while disabled is not captured on re-enable
        en = 1'b0;
        drive(8'h5A, 0);
        en = 1'b1;
        step();
        chk("en_nopush", level, 0);
        drive(8'h5B, 1);
        chk("en_push", level, 1);
        chk("en_head", out_data, 8'h5B);
        out_ready = 1'b1;
        repeat (2) step();
        out_ready = 1'b0;

        chk("sb_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
